// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operation sequencer: state encodings,
// opcode constants and default widths.
package alu_pkg;

  localparam int WIDTH_DEF   = 6;
  localparam int OP_W_DEF    = 4;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_RUN  = 3'd3,
    S_WAIT = 3'd4,
    S_SHOW = 3'd5
  } state_e;

  localparam logic [3:0] OP_AND   = 4'd0;
  localparam logic [3:0] OP_OR    = 4'd1;
  localparam logic [3:0] OP_XOR   = 4'd2;
  localparam logic [3:0] OP_XNOR  = 4'd3;
  localparam logic [3:0] OP_ADD   = 4'd4;
  localparam logic [3:0] OP_SUB   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_PASSA = 4'd7;

  // States in which a user step loads a value from the switches.
  function automatic logic is_load_state(input state_e s);
    return (s == S_A) || (s == S_B) || (s == S_OP);
  endfunction

endpackage

// File: rtl/alu_seq_timeout_ctr.sv
// Down-counter for the WAIT timeout: load on entry, count down while enabled,
// expire_o is high once the count reaches zero.
module alu_seq_timeout_ctr
  import alu_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Step-driven sequencer: latches A, B and opcode from switches, runs one ALU
// start/done handshake and holds the result. Optional WAIT timeout: ALU_SEQ_TIMEOUT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int OP_W    = OP_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_step,
  input  logic [WIDTH-1:0] sw_data,
  input  logic [OP_W-1:0]  sw_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic [2:0]       state_led,
  output logic             error
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             start_q, start_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             timeout_hit;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic ctr_expire;

  alu_seq_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk      (clk),
    .reset    (reset),
    .load_i   (state_q == S_RUN),
    .en_i     (state_q == S_WAIT),
    .expire_o (ctr_expire)
  );

  assign timeout_hit = ctr_expire && (state_q == S_WAIT);
`else
  // Without the timeout feature WAIT never gives up; TIMEOUT has no effect.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  always_comb begin
    state_d  = state_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    start_d  = 1'b0;
    valid_d  = valid_q;
    error_d  = error_q;

    case (state_q)
      S_A: begin
        if (btn_step) begin
          alu_a_d = sw_data;
          state_d = S_B;
        end
      end
      S_B: begin
        if (btn_step) begin
          alu_b_d = sw_data;
          state_d = S_OP;
        end
      end
      S_OP: begin
        // start is registered so it is high exactly during the RUN cycle
        if (btn_step) begin
          alu_op_d = sw_op;
          start_d  = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // a real done outranks a timeout landing in the same cycle
        if (alu_done) begin
          result_d = alu_result;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end else if (timeout_hit) begin
          result_d = '1;
          error_d  = 1'b1;
          valid_d  = 1'b1;
          state_d  = S_SHOW;
        end
      end
      S_SHOW: begin
        if (btn_step) begin
          valid_d = 1'b0;
          error_d = 1'b0;
          state_d = S_A;
        end
      end
      default: begin
        valid_d = 1'b0;
        error_d = 1'b0;
        state_d = S_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_A;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      result_q <= '0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_op       = alu_op_q;
  assign alu_start    = start_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign state_led    = state_q;
  assign error        = error_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer; the bench plays the ALU by hand.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_step;
  logic [5:0] sw_data;
  logic [3:0] sw_op;
  logic [5:0] alu_a, alu_b;
  logic [3:0] alu_op;
  logic       alu_start;
  logic       alu_done;
  logic [5:0] alu_result;
  logic [5:0] result;
  logic       result_valid;
  logic [2:0] state_led;
  logic       error;

  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;

  always #5 clk = ~clk;

  alu_op_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .btn_step     (btn_step),
    .sw_data      (sw_data),
    .sw_op        (sw_op),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_start    (alu_start),
    .alu_done     (alu_done),
    .alu_result   (alu_result),
    .result       (result),
    .result_valid (result_valid),
    .state_led    (state_led),
    .error        (error)
  );

  always @(posedge clk) begin
    if (alu_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                           input logic [3:0] op);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_XNOR: return ~(a ^ b);
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_NOT:  return ~a;
      default: return a;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge after the step was sampled.
  task automatic step(input logic [5:0] d, input logic [3:0] op);
    sw_data  = d;
    sw_op    = op;
    btn_step = 1'b1;
    @(negedge clk);
    btn_step = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    btn_step   = 1'b0;
    sw_data    = '0;
    sw_op      = '0;
    alu_done   = 1'b0;
    alu_result = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_state", state_led, 0);
    chk("rst_a", alu_a, 0);
    chk("rst_b", alu_b, 0);
    chk("rst_op", alu_op, 0);
    chk("rst_result", result, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_start", alu_start, 0);
    chk("rst_error", error, 0);
    reset = 1'b0;
    @(negedge clk);

    // Full flow: 101010 XNOR 110011 = 100110, extra steps in RUN/WAIT ignored
    step(6'b101010, 4'd0);
    chk("flow_state_b", state_led, 1);
    chk("flow_a", alu_a, 6'b101010);
    step(6'b110011, 4'd0);
    chk("flow_state_op", state_led, 2);
    chk("flow_b", alu_b, 6'b110011);
    step(6'b000000, OP_XNOR);
    chk("flow_start", alu_start, 1);
    chk("flow_state_run", state_led, 3);
    chk("flow_op", alu_op, OP_XNOR);
    btn_step = 1'b1;
    @(negedge clk);
    chk("flow_state_wait", state_led, 4);
    chk("flow_start_low", alu_start, 0);
    @(negedge clk);
    btn_step = 1'b0;
    chk("flow_wait_hold", state_led, 4);
    alu_done   = 1'b1;
    alu_result = alu_model(alu_a, alu_b, alu_op);
    @(negedge clk);
    alu_done = 1'b0;
    chk("flow_result", result, 6'b100110);
    chk("flow_valid", result_valid, 1);
    chk("flow_state_show", state_led, 5);
    chk("flow_start_cnt", start_cnt, 1);
    chk("flow_error", error, 0);

    // Leave SHOW, then a spurious done in S_A
    step(6'h00, 4'd0);
    chk("show_exit_state", state_led, 0);
    chk("show_exit_valid", result_valid, 0);
    chk("show_exit_held", result, 6'b100110);
    alu_done   = 1'b1;
    alu_result = 6'h15;
    @(negedge clk);
    alu_done = 1'b0;
    chk("spur_state", state_led, 0);
    chk("spur_result", result, 6'b100110);
    chk("spur_start_cnt", start_cnt, 1);

    // Back-to-back: 3F AND 01 = 01, previous result held until capture
    step(6'h3F, 4'd0);
    chk("b2b_held_a", result, 6'b100110);
    step(6'h01, 4'd0);
    step(6'h00, OP_AND);
    chk("b2b_start", alu_start, 1);
    chk("b2b_held_run", result, 6'b100110);
    @(negedge clk);
    @(negedge clk);
    chk("b2b_held_wait", result, 6'b100110);
    alu_done   = 1'b1;
    alu_result = alu_model(alu_a, alu_b, alu_op);
    @(negedge clk);
    alu_done = 1'b0;
    chk("b2b_result", result, 6'h01);
    chk("b2b_state", state_led, 5);
    chk("b2b_start_cnt", start_cnt, 2);

    // Done coincident with start is ignored; the one a cycle later is captured (5+3=8)
    step(6'h00, 4'd0);
    step(6'h05, 4'd0);
    step(6'h03, 4'd0);
    step(6'h00, OP_ADD);
    chk("same_start", alu_start, 1);
    alu_done   = 1'b1;
    alu_result = 6'h2A;
    @(negedge clk);
    chk("same_state_wait", state_led, 4);
    chk("same_not_captured", result, 6'h01);
    alu_result = alu_model(alu_a, alu_b, alu_op);
    @(negedge clk);
    alu_done = 1'b0;
    chk("same_result", result, 6'h08);
    chk("same_state_show", state_led, 5);

    // Reset while in WAIT, then a late done
    step(6'h00, 4'd0);
    step(6'h07, 4'd0);
    step(6'h09, 4'd0);
    step(6'h00, OP_OR);
    @(negedge clk);
    chk("rw_state_wait", state_led, 4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rw_state", state_led, 0);
    chk("rw_a", alu_a, 0);
    chk("rw_b", alu_b, 0);
    chk("rw_op", alu_op, 0);
    chk("rw_result", result, 0);
    chk("rw_valid", result_valid, 0);
    chk("rw_start", alu_start, 0);
    alu_done   = 1'b1;
    alu_result = 6'h3F;
    @(negedge clk);
    alu_done = 1'b0;
    chk("late_state", state_led, 0);
    chk("late_result", result, 0);
    chk("late_valid", result_valid, 0);

`ifdef ALU_SEQ_TIMEOUT_EN
    // No done: SHOW 16 cycles after entering WAIT, result all ones, error set
    step(6'h11, 4'd0);
    step(6'h22, 4'd0);
    step(6'h00, OP_SUB);
    repeat (16) @(negedge clk);
    chk("to_still_wait", state_led, 4);
    chk("to_no_error_yet", error, 0);
    @(negedge clk);
    chk("to_state_show", state_led, 5);
    chk("to_result", result, 6'h3F);
    chk("to_error", error, 1);
    chk("to_valid", result_valid, 1);
    step(6'h00, 4'd0);
    chk("to_error_clr", error, 0);
    chk("to_state_a", state_led, 0);
`else
    chk("no_to_error", error, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
